// File: rtl/des_sbox_engine_if.sv
// ============================================================================
//  Module      : des_sbox_if
//  Description : Handshake bundle for the DES S-box engine. The slave
//                modport is the engine side; master is the producer/consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface des_sbox_if;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/des_sbox_engine.sv
// ============================================================================
//  Module      : des_sbox_engine
//  Description : DES S-box substitution engine. LANES lookups per cycle are
//                time-multiplexed over S1..S8; a 48-bit expanded half-block
//                becomes a 32-bit result after 8/LANES busy cycles.
//                Optional macro SBOX_PBOX_EN applies the DES P permutation
//                to the result as it is loaded into out_data.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module des_sbox_engine #(
  parameter int LANES = 2
) (
  input  logic       clk,
  input  logic       rst,
  des_sbox_if.slave  bus
);

  localparam int         c_GROUPS   = 8 / LANES;
  localparam logic [2:0] c_LAST_GRP = 3'(c_GROUPS - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_lanes_check
    $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
  end

  // One S-box lookup: row = {b5,b0}, column = b[4:1]. Each table is stored
  // row-major with entry 0 in the top nibble, so entry i sits at bit
  // 255-4*i, i.e. index {~i, 2'b11}.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] b);
    logic [255:0] tbl;
    logic [5:0]   idx;
    case (box)
      3'd0: tbl = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
      3'd1: tbl = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
      3'd2: tbl = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
      3'd3: tbl = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
      3'd4: tbl = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
      3'd5: tbl = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
      3'd6: tbl = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
      default: tbl = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
    endcase
    idx = {b[5], b[0], b[4:1]};
    return tbl[{~idx, 2'b11} -: 4];
  endfunction

`ifdef SBOX_PBOX_EN
  // DES P permutation: output bit n (1 = MSB) takes input bit P[n].
  function automatic logic [31:0] pbox(input logic [31:0] x);
    return {x[16], x[25], x[12], x[11], x[3],  x[20], x[4],  x[15],
            x[31], x[17], x[9],  x[6],  x[27], x[14], x[1],  x[22],
            x[30], x[24], x[8],  x[18], x[0],  x[5],  x[29], x[23],
            x[13], x[19], x[2],  x[26], x[10], x[21], x[28], x[7]};
  endfunction
`endif

  // Packed so that index 7 is S1's group / nibble and index 0 is S8's;
  // box number b (0 = S1) therefore lives at index ~b.
  logic [1:0]            state_q, state_d;
  logic [2:0]            grp_q, grp_d;
  logic [7:0][5:0]       data_q, data_d;
  logic [7:0][3:0]       acc_q, acc_d;
  logic [31:0]           out_data_q, out_data_d;

  logic                  w_in_ready;
  logic                  w_accept;
  logic [LANES-1:0][2:0] w_box;
  logic [LANES-1:0][3:0] w_nib;

  assign w_in_ready    = (state_q == c_IDLE) || ((state_q == c_DONE) && bus.out_ready);
  assign w_accept      = bus.in_valid && w_in_ready;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (state_q == c_DONE);
  assign bus.busy      = (state_q == c_BUSY);
  assign bus.out_data  = out_data_q;

  // Lane l handles box grp*LANES + l in the current busy cycle.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_box[l] = 3'(int'(grp_q) * LANES + l);
    assign w_nib[l] = sbox_lookup(w_box[l], data_q[~w_box[l]]);
  end

  // Next-state logic: handshake, group sequencing and accumulator writes.
  always_comb begin
    state_d    = state_q;
    grp_d      = grp_q;
    data_d     = data_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    case (state_q)
      c_IDLE: begin
        if (w_accept) begin
          state_d = c_BUSY;
          grp_d   = 3'd0;
          data_d  = bus.in_data;
        end
      end
      c_BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          acc_d[~w_box[l]] = w_nib[l];
        end
        if (grp_q == c_LAST_GRP) begin
          state_d = c_DONE;
          // Load from acc_d so the final group's nibbles are included.
`ifdef SBOX_PBOX_EN
          out_data_d = pbox(acc_d);
`else
          out_data_d = acc_d;
`endif
        end else begin
          grp_d = grp_q + 3'd1;
        end
      end
      c_DONE: begin
        if (bus.out_ready) begin
          if (w_accept) begin
            state_d = c_BUSY;
            grp_d   = 3'd0;
            data_d  = bus.in_data;
          end else begin
            state_d = c_IDLE;
          end
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  // State registers with synchronous reset taking priority over handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= c_IDLE;
      grp_q      <= 3'd0;
      data_q     <= '0;
      acc_q      <= '0;
      out_data_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      grp_q      <= grp_d;
      data_q     <= data_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_des_sbox_engine.sv
// ============================================================================
//  Module      : tb_des_sbox_engine
//  Description : Self-checking bench; four engines with LANES = 1, 2, 4, 8
//                share clk/rst, each driven through its own interface.
//                Expected results come from a table-based software model
//                and the published DES vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_des_sbox_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  in_valid = '0;
  logic [3:0]  out_ready = '0;
  logic [47:0] in_data [4];
  wire  [3:0]  in_ready;
  wire  [3:0]  out_valid;
  wire  [3:0]  busy;
  wire  [31:0] out_data [4];

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  // DUT index d uses LANES = 1 << d.
  for (genvar d = 0; d < 4; d++) begin : g_dut
    des_sbox_if bus ();
    assign bus.in_valid  = in_valid[d];
    assign bus.in_data   = in_data[d];
    assign bus.out_ready = out_ready[d];
    assign in_ready[d]   = bus.in_ready;
    assign out_valid[d]  = bus.out_valid;
    assign out_data[d]   = bus.out_data;
    assign busy[d]       = bus.busy;
    des_sbox_engine #(.LANES(1 << d)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  end

  // FIPS 46-3 S-boxes, row-major, decimal.
  localparam int c_SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  function automatic logic [31:0] model_sub(input logic [47:0] x);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      int g;
      int row;
      int col;
      g   = int'(x >> (42 - 6 * j)) & 63;
      row = ((g >> 4) & 2) | (g & 1);
      col = (g >> 1) & 15;
      r   = (r << 4) | 32'(c_SBOX[j][row * 16 + col]);
    end
    return r;
  endfunction

`ifdef SBOX_PBOX_EN
  localparam int c_PTAB [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                                 2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};

  function automatic logic [31:0] model_p(input logic [31:0] x);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r = (r << 1) | ((x >> (32 - c_PTAB[i])) & 32'd1);
    end
    return r;
  endfunction
`endif

  function automatic logic [31:0] finish_res(input logic [31:0] v);
`ifdef SBOX_PBOX_EN
    return model_p(v);
`else
    return v;
`endif
  endfunction

  // Published vectors for the all-zero / all-one inputs, model otherwise.
  function automatic logic [31:0] expect_for(input logic [47:0] x);
    if (x == 48'h0) return finish_res(32'hEFA72C4D);
    if (x == 48'hFFFF_FFFF_FFFF) return finish_res(32'hD9CE3DCB);
    return finish_res(model_sub(x));
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 4'hF;
    out_ready = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 4'h0;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      n_cmp++; if (in_ready[d] !== 1'b1) begin n_err++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", d, in_ready[d]); end
      n_cmp++; if (out_valid[d] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", d, out_valid[d]); end
      n_cmp++; if (busy[d] !== 1'b0) begin n_err++; $display("FAIL reset_busy[%0d]: got %b expected 0", d, busy[d]); end
      n_cmp++; if (out_data[d] !== 32'h0) begin n_err++; $display("FAIL reset_out_data[%0d]: got %h expected 00000000", d, out_data[d]); end
    end
    // Handshake offered while rst was high must not have started a job.
    @(posedge clk); #1;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      n_cmp++; if (busy[d] !== 1'b0) begin n_err++; $display("FAIL reset_priority_busy[%0d]: got %b expected 0", d, busy[d]); end
    end
    out_ready = 4'h0;
  endtask

  task automatic test_latency(input int d, input logic [47:0] x);
    int          lat;
    bit          seen;
    logic [31:0] e;
    @(posedge clk); #1;
    in_valid[d] = 1'b1;
    in_data[d] = x;
    out_ready[d] = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready[d] !== 1'b1) begin n_err++; $display("FAIL lat_idle_ready[%0d]: got %b expected 1", d, in_ready[d]); end
    if (in_valid[d] && in_ready[d]) sb.push_back(expect_for(x));
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    in_data[d] = ~x;
    lat = 0;
    seen = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy[d] !== 1'b1) begin n_err++; $display("FAIL lat_busy[%0d]: got %b expected 1", d, busy[d]); end
    while (!seen && lat < 20) begin
      if (out_valid[d] === 1'b1) seen = 1'b1;
      else begin @(posedge clk); #1; lat++; @(negedge clk); end
    end
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL lat_timeout[%0d]: got no out_valid in 20 cycles expected %0d", d, 8 >> d);
      sb.delete();
    end else begin
      if (lat != (8 >> d)) begin n_err++; $display("FAIL lat_cycles[%0d]: got %0d expected %0d", d, lat, 8 >> d); end
      n_cmp++;
      if (sb.size() == 0) begin n_err++; $display("FAIL lat_sb_empty[%0d]: got output expected none", d); end
      else begin
        e = sb.pop_front();
        if (out_data[d] !== e) begin n_err++; $display("FAIL lat_data[%0d] in=%h: got %h expected %h", d, x, out_data[d], e); end
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin n_err++; $display("FAIL lat_return_idle[%0d]: got valid=%b ready=%b expected valid=0 ready=1", d, out_valid[d], in_ready[d]); end
    end
    out_ready[d] = 1'b0;
  endtask

  task automatic test_backpressure();
    int          n;
    logic [31:0] e;
    @(posedge clk); #1;
    in_valid[0] = 1'b1;
    in_data[0] = 48'h0;
    out_ready[0] = 1'b0;
    @(negedge clk);
    if (in_valid[0] && in_ready[0]) sb.push_back(expect_for(48'h0));
    @(posedge clk); #1;
    in_data[0] = 48'hFFFF_FFFF_FFFF;  // offered while busy; must be ignored
    n = 0;
    @(negedge clk);
    while (out_valid[0] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; @(negedge clk); end
    e = (sb.size() != 0) ? sb[0] : 32'hXXXX_XXXX;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid[0] !== 1'b1) begin n_err++; $display("FAIL bp_valid cyc%0d: got %b expected 1", i, out_valid[0]); end
      n_cmp++; if (out_data[0] !== e) begin n_err++; $display("FAIL bp_data cyc%0d: got %h expected %h", i, out_data[0], e); end
      n_cmp++; if (in_ready[0] !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc%0d: got %b expected 0", i, in_ready[0]); end
      if (i < 4) begin @(posedge clk); #1; @(negedge clk); end
    end
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (sb.size() == 0 || out_valid[0] !== 1'b1) begin n_err++; $display("FAIL bp_release: got valid=%b queue=%0d expected valid=1 queue=1", out_valid[0], sb.size()); end
    else begin
      e = sb.pop_front();
      if (out_data[0] !== e) begin n_err++; $display("FAIL bp_release_data: got %h expected %h", out_data[0], e); end
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1) begin n_err++; $display("FAIL bp_idle: got valid=%b busy=%b ready=%b expected 0 0 1", out_valid[0], busy[0], in_ready[0]); end
    n_cmp++; if (out_data[0] !== e) begin n_err++; $display("FAIL bp_data_hold: got %h expected %h", out_data[0], e); end
  endtask

  task automatic test_back_to_back();
    logic [47:0] stim [3];
    logic [31:0] e;
    int          idx;
    int          nres;
    int          cyc;
    int          last_acc;
    stim[0] = 48'h0;
    stim[1] = 48'hFFFF_FFFF_FFFF;
    stim[2] = {16'($urandom), $urandom};
    idx = 0; nres = 0; cyc = 0; last_acc = -1;
    @(posedge clk); #1;
    out_ready[2] = 1'b1;
    in_valid[2] = 1'b1;
    in_data[2] = stim[0];
    while (nres < 3 && cyc < 60) begin
      @(negedge clk);
      if (out_valid[2] && out_ready[2]) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL b2b_sb_empty: got output %h expected none", out_data[2]); end
        else begin
          e = sb.pop_front();
          if (out_data[2] !== e) begin n_err++; $display("FAIL b2b_data%0d: got %h expected %h", nres, out_data[2], e); end
        end
        nres++;
      end
      if (in_valid[2] && in_ready[2]) begin
        sb.push_back(expect_for(in_data[2]));
        if (last_acc >= 0) begin
          n_cmp++; if (cyc - last_acc != 3) begin n_err++; $display("FAIL b2b_spacing: got %0d expected 3", cyc - last_acc); end
        end
        last_acc = cyc;
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
      if (idx < 3) in_data[2] = stim[idx];
      else in_valid[2] = 1'b0;
    end
    n_cmp++; if (nres != 3) begin n_err++; $display("FAIL b2b_count: got %0d expected 3", nres); end
    out_ready[2] = 1'b0;
    in_valid[2] = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset_mid();
    int nvalid;
    @(posedge clk); #1;
    in_valid[1] = 1'b1;
    in_data[1] = 48'h0;
    out_ready[1] = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready[1] !== 1'b1) begin n_err++; $display("FAIL rstmid_accept: got %b expected 1", in_ready[1]); end
    @(posedge clk); #1;             // accept edge; first busy cycle follows
    in_valid[1] = 1'b0;
    @(posedge clk); #1;             // second busy cycle
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_data[1] !== 32'h0) begin n_err++; $display("FAIL rstmid_out_data: got %h expected 00000000", out_data[1]); end
    n_cmp++; if (in_ready[1] !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready[1]); end
    n_cmp++; if (busy[1] !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", busy[1]); end
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid[1] !== 1'b0) nvalid++;
      @(posedge clk); #1; @(negedge clk);
    end
    n_cmp++; if (nvalid != 0) begin n_err++; $display("FAIL rstmid_no_valid: got %0d valid cycles expected 0", nvalid); end
    out_ready[1] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 4; d++) in_data[d] = 48'h0;
    test_reset();
    for (int d = 0; d < 4; d++) begin
      test_latency(d, 48'h0);
      test_latency(d, 48'hFFFF_FFFF_FFFF);
      test_latency(d, 48'h1234_5678_9ABC);
      test_latency(d, {16'($urandom), $urandom});
    end
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation time limit expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
